// File: rtl/core_run_ctrl.sv
// Run controller: holds core resets, runs the cores, ends on halt or budget.
// Optional per-core reset stagger enabled by `define CORE_RUN_CTRL_STAGGER_EN.
module core_run_ctrl #(
  parameter int N_CORES    = 1,
  parameter int RST_CYCLES = 5,
  parameter int RUN_CYCLES = 186,
  parameter int CNT_WIDTH  = 16,
  parameter int STAGGER    = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [N_CORES-1:0]   i_halt,
  output logic [N_CORES-1:0]   o_core_rst,
  output logic                 o_running,
  output logic                 o_done,
  output logic                 o_timeout,
  output logic [CNT_WIDTH-1:0] o_cycles
);

`ifdef CORE_RUN_CTRL_STAGGER_EN
  localparam int STG = STAGGER;
`else
  localparam int STG = 0 * STAGGER;
`endif

  localparam logic [CNT_WIDTH-1:0] ONE =
    CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] RUN_LAST =
    CNT_WIDTH'(RUN_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] RUN_MAX =
    CNT_WIDTH'(RUN_CYCLES);
  // Reset window spans core 0's hold plus the stagger of the last core.
  localparam logic [CNT_WIDTH-1:0] RST_LOAD =
    CNT_WIDTH'(RST_CYCLES + (N_CORES - 1) * STG);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_WIDTH-1:0] rst_cnt_q, rst_cnt_d;
  logic [CNT_WIDTH-1:0] cyc_d;
  logic [N_CORES-1:0]   core_rst_d;
  logic                 running_d;
  logic                 done_d;
  logic                 timeout_d;
  logic                 all_halt;

  assign all_halt = &i_halt;

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    cyc_d      = o_cycles;
    core_rst_d = o_core_rst;
    timeout_d  = o_timeout;
    unique case (state_q)
      S_IDLE: begin
        core_rst_d = '1;
        if (i_start) begin
          state_d   = S_RESET;
          rst_cnt_d = RST_LOAD;
          cyc_d     = '0;
          timeout_d = 1'b0;
        end
      end
      S_RESET: begin
        if (i_abort) begin
          state_d    = S_IDLE;
          core_rst_d = '1;
        end else if (rst_cnt_q == '0) begin
          state_d    = S_RUN;
          core_rst_d = '0;
        end else begin
          rst_cnt_d = rst_cnt_q - ONE;
`ifdef CORE_RUN_CTRL_STAGGER_EN
          // Core j drops reset once the countdown reaches its offset.
          for (int j = 0; j < N_CORES; j++) begin
            if (rst_cnt_q <=
                CNT_WIDTH'((N_CORES - 1 - j) * STG))
              core_rst_d[j] = 1'b0;
          end
`endif
        end
      end
      S_RUN: begin
        core_rst_d = '0;
        if (i_abort) begin
          state_d    = S_IDLE;
          core_rst_d = '1;
        end else if (all_halt) begin
          state_d    = S_DONE;
          core_rst_d = '1;
          timeout_d  = 1'b0;
        end else if (o_cycles == RUN_LAST) begin
          state_d    = S_DONE;
          core_rst_d = '1;
          timeout_d  = 1'b1;
          cyc_d      = RUN_MAX;
        end else begin
          cyc_d = o_cycles + ONE;
        end
      end
      S_DONE: begin
        core_rst_d = '1;
        if (i_start) begin
          state_d   = S_RESET;
          rst_cnt_d = RST_LOAD;
          cyc_d     = '0;
          timeout_d = 1'b0;
        end
      end
    endcase
    running_d = (state_d == S_RUN);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      rst_cnt_q  <= '0;
      o_core_rst <= '1;
      o_running  <= 1'b0;
      o_done     <= 1'b0;
      o_timeout  <= 1'b0;
      o_cycles   <= '0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      o_core_rst <= core_rst_d;
      o_running  <= running_d;
      o_done     <= done_d;
      o_timeout  <= timeout_d;
      o_cycles   <= cyc_d;
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl in its default configuration.
// Run outcomes are queued by stimulus and checked by a done monitor.
module tb_core_run_ctrl;

  localparam int RST = 5;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        i_abort;
  logic [0:0]  i_halt;
  logic [0:0]  o_core_rst;
  logic        o_running;
  logic        o_done;
  logic        o_timeout;
  logic [15:0] o_cycles;

  typedef struct {
    logic        to;
    logic [15:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  logic done_prev = 1'b0;

  core_run_ctrl dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_abort    (i_abort),
    .i_halt     (i_halt),
    .o_core_rst (o_core_rst),
    .o_running  (o_running),
    .o_done     (o_done),
    .o_timeout  (o_timeout),
    .o_cycles   (o_cycles)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d",
               name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_core_rst"}, 32'(o_core_rst), 1);
    chk({tag, "_running"}, 32'(o_running), 0);
    chk({tag, "_done"}, 32'(o_done), 0);
    chk({tag, "_timeout"}, 32'(o_timeout), 0);
    chk({tag, "_cycles"}, 32'(o_cycles), 0);
  endtask

  // Start pulse at edge k; reset held through k+5, released at k+6.
  task automatic start_run();
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    for (int i = 0; i <= RST; i++) begin
      chk("rst_hold", 32'(o_core_rst), 1);
      chk("rst_not_running", 32'(o_running), 0);
      tick(1);
    end
    chk("release_core_rst", 32'(o_core_rst), 0);
    chk("release_running", 32'(o_running), 1);
    chk("release_cycles", 32'(o_cycles), 0);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!o_done && n < budget) begin
      tick(1);
      n++;
    end
    if (!o_done) begin
      total++;
      bad++;
      $display("FAIL wait_done: got timeout after %0d want done",
               n);
    end
  endtask

  always @(negedge i_clk) begin
    exp_t e;
    if (o_done && !done_prev) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done: got done want none");
      end else begin
        e = exp_q.pop_front();
        chk("mon_timeout", 32'(o_timeout), 32'(e.to));
        chk("mon_cycles", 32'(o_cycles), 32'(e.cyc));
        chk("mon_core_rst", 32'(o_core_rst), 1);
        chk("mon_running", 32'(o_running), 0);
      end
    end
    done_prev = o_done;
  end

  initial begin
    i_rst   = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_halt  = 1'b0;
    tick(5);
    chk_reset_vals("reset");
    i_rst = 1'b0;
    tick(4);
    chk_reset_vals("idle");

    // budget expiry
    start_run();
    tick(100);
    chk("run_count_100", 32'(o_cycles), 100);
    exp_q.push_back('{to: 1'b1, cyc: 16'd186});
    wait_done(200);
    chk("timeout_cycles_direct", 32'(o_cycles), 186);
    tick(3);
    chk("done_hold", 32'(o_cycles), 186);

    // halt at RUN cycle 40
    start_run();
    tick(40);
    chk("pre_halt_cycles", 32'(o_cycles), 40);
    i_halt = 1'b1;
    exp_q.push_back('{to: 1'b0, cyc: 16'd40});
    tick(1);
    i_halt = 1'b0;
    chk("halt_done", 32'(o_done), 1);
    tick(1);

    // halt on the final budget cycle
    start_run();
    tick(185);
    chk("last_cycle", 32'(o_cycles), 185);
    i_halt = 1'b1;
    exp_q.push_back('{to: 1'b0, cyc: 16'd185});
    tick(1);
    i_halt = 1'b0;
    chk("last_halt_done", 32'(o_done), 1);
    tick(1);

    // abort together with start at RUN cycle 20
    start_run();
    tick(10);
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    chk("start_ignored_run", 32'(o_cycles), 11);
    tick(9);
    chk("pre_abort_cycles", 32'(o_cycles), 20);
    i_abort = 1'b1;
    i_start = 1'b1;
    tick(1);
    i_abort = 1'b0;
    i_start = 1'b0;
    chk("abort_done", 32'(o_done), 0);
    chk("abort_core_rst", 32'(o_core_rst), 1);
    chk("abort_running", 32'(o_running), 0);
    chk("abort_cycles", 32'(o_cycles), 20);
    i_abort = 1'b1;
    tick(3);
    i_abort = 1'b0;
    chk("idle_abort_noop", 32'(o_cycles), 20);
    start_run();

    // reset pulse mid-run
    tick(30);
    i_halt = 1'b1;
    i_rst  = 1'b1;
    tick(1);
    i_rst  = 1'b0;
    chk_reset_vals("midrun_rst");
    i_halt = 1'b0;
    tick(3);
    chk_reset_vals("post_rst_idle");

    // abort during the reset window
    i_start = 1'b1;
    tick(1);
    i_start = 1'b0;
    tick(2);
    i_abort = 1'b1;
    tick(1);
    i_abort = 1'b0;
    chk("rst_abort_core_rst", 32'(o_core_rst), 1);
    tick(8);
    chk("rst_abort_idle", 32'(o_running), 0);

    tick(3);
    chk("queue_empty", 32'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
